// File: rtl/mux8_sel_arb.sv
// mux8_sel_arb: round-robin arbiter driving the select of an 8:1 mux; define MUX8_ARB_HOLD_LIMIT_EN to cap beats per grant at HOLD_MAX
module mux8_sel_arb #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid
);
  localparam int BW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [2:0] ptr, ptr_d, sel_d, w;
  logic [7:0] gnt_d;
  logic valid_d, beat, rel;
  logic [BW-1:0] beats, beats_d;
  assign beat = valid && ready;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
  localparam logic [BW-1:0] HMAX = BW'(HOLD_MAX);
  assign rel = (beat && done) || !req[sel] || (beat && beats + BW'(1) == HMAX);
`else
  assign rel = (beat && done) || !req[sel];
`endif
  // first requesting channel found scanning cyclically upward from ptr
  always_comb begin
    w = ptr;
    for (int i = 7; i >= 0; i--)
      if (req[ptr + 3'(i)]) w = ptr + 3'(i);
  end
  // next-state: grant from IDLE, release or count beats in GRANT
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    sel_d = sel;
    gnt_d = gnt;
    valid_d = valid;
    beats_d = beats;
    if (state == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        sel_d = w;
        gnt_d = 8'b1 << w;
        valid_d = 1'b1;
        beats_d = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      valid_d = 1'b0;
      gnt_d = '0;
      beats_d = '0;
      ptr_d = sel + 3'd1;
    end else if (beat && beats != '1) begin
      beats_d = beats + BW'(1);
    end
  end
  // state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      gnt <= '0;
      valid <= 1'b0;
      beats <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      sel <= sel_d;
      gnt <= gnt_d;
      valid <= valid_d;
      beats <= beats_d;
    end
  end
endmodule

// File: tb/tb_mux8_sel_arb.sv
// tb_mux8_sel_arb: directed checks of the round-robin mux select arbiter
module tb_mux8_sel_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic done = 1'b0;
  logic ready = 1'b0;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic valid;
  int npass = 0;
  int ntot = 0;
  mux8_sel_arb #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .ready(ready),
    .sel(sel), .gnt(gnt), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    rst_n = 1'b0;
    req = '0;
    done = 1'b0;
    ready = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask
  task automatic chk_grant(input string tag, input logic [2:0] ch);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(ch));
    chk({tag, "_gnt"}, 32'(gnt), 32'(8'b1 << ch));
  endtask
  initial begin
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_req", 32'(valid), 32'd0);
    req = 8'h10;
    ready = 1'b1;
    step();
    chk_grant("single", 3'd4);
    step();
    chk_grant("hold_b1", 3'd4);
    step();
    chk_grant("hold_b2", 3'd4);
    done = 1'b1;
    step();
    chk("done_rel_valid", 32'(valid), 32'd0);
    chk("done_rel_gnt", 32'(gnt), 32'd0);
    chk("done_rel_sel_kept", 32'(sel), 32'd4);
    done = 1'b0;
    req = 8'h31;
    step();
    chk_grant("ptr5", 3'd5);
    rst_pulse();
    req = 8'hFF;
    ready = 1'b1;
    done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_grant($sformatf("rr%0d", k), 3'(k));
      step();
      chk($sformatf("rr_gap%0d", k), 32'(valid), 32'd0);
    end
    rst_pulse();
    req = 8'h24;
    step();
    chk_grant("drop_g2", 3'd2);
    step();
    chk_grant("drop_hold", 3'd2);
    req = 8'h22;
    step();
    chk("drop_rel", 32'(valid), 32'd0);
    step();
    chk_grant("drop_next5", 3'd5);
    rst_pulse();
    req = 8'h01;
    ready = 1'b1;
    step();
    chk_grant("lim_g0", 3'd0);
`ifdef MUX8_ARB_HOLD_LIMIT_EN
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("lim_b%0d", k), 32'(valid), 32'd1);
    end
    step();
    chk("lim_rel", 32'(valid), 32'd0);
    step();
    chk_grant("lim_regrant", 3'd0);
`else
    for (int k = 1; k <= 25; k++) begin
      step();
      chk($sformatf("nolim_b%0d", k), 32'(valid), 32'd1);
    end
`endif
    rst_pulse();
    req = 8'h48;
    ready = 1'b1;
    step();
    chk_grant("sim_g3", 3'd3);
    for (int k = 1; k < 4; k++) step();
    chk_grant("sim_b3", 3'd3);
    done = 1'b1;
    req = 8'h40;
    step();
    chk("sim_rel", 32'(valid), 32'd0);
    done = 1'b0;
    req = 8'h30;
    step();
    chk_grant("sim_ptr4", 3'd4);
    rst_pulse();
    req = 8'h80;
    step();
    chk_grant("ar_g7", 3'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_gnt", 32'(gnt), 32'd0);
    chk("ar_sel", 32'(sel), 32'd0);
    req = 8'h81;
    #3;
    rst_n = 1'b1;
    step();
    chk_grant("ar_restart0", 3'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
